time_base_gen: RTL

TIME_BASE_GEN -- requirements
Module: time_base_gen

---
 rtl/time_base_pkg.sv | 13 +
 rtl/time_base_gen_mt_gen.sv | 50 +++++
 rtl/time_base_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/time_base_pkg.sv
// Shared types and default sizes for the time base generator.
package time_base_pkg;

  localparam int unsigned CNT_W_DEF   = 64;
  localparam int unsigned PRESC_W_DEF = 16;
  localparam int unsigned SLOT_W_DEF  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } set_state_t;

endpackage

// File: rtl/time_base_gen_mt_gen.sv
// Macrotick event source: internal prescaler or external mtclk rising edge.
module mt_gen
  import time_base_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mtclk,
  input  logic               mt_sel,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               mt_evt_c
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_d;
  logic               mtclk_q;
  logic               sel_q;
  logic               sel_chg;

  // Event decode; a source switch restarts the prescaler and drops that cycle's event.
  always_comb begin
    sel_chg  = (mt_sel != sel_q);
    presc_d  = '0;
    mt_evt_c = 1'b0;
    if (!sel_chg) begin
      if (mt_sel) begin
        mt_evt_c = mtclk & ~mtclk_q;
      end else if (presc == presc_div) begin
        mt_evt_c = 1'b1;
      end else begin
        presc_d = presc + PRESC_W'(1);
      end
    end
  end

  // Prescaler, mtclk history and source history; mtclk_q resets high so a held-high mtclk is no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      mtclk_q <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      presc   <= presc_d;
      mtclk_q <= mtclk;
      sel_q   <= mt_sel;
    end
  end

endmodule

// File: rtl/time_base_gen.sv
// Global time counter with immediate/deferred load and slot tick generation.
module time_base_gen
  import time_base_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF,
  parameter int unsigned SLOT_W  = SLOT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mtclk,
  input  logic               mt_sel,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               set_req,
  input  logic               set_mode,
  input  logic [CNT_W-1:0]   new_time,
  input  logic [CNT_W-1:0]   reconf_time,
  input  logic               set_cancel,
  input  logic [SLOT_W-1:0]  slot_len,
  output logic [CNT_W-1:0]   time_cnt,
  output logic               mt_pulse,
  output logic               slot_tick,
  output logic [SLOT_W-1:0]  slot_cnt,
  output logic               set_ack,
  output logic               set_pending
);

  logic               evt_c;
  set_state_t         state, state_d;
  logic [CNT_W-1:0]   time_d;
  logic [SLOT_W-1:0]  slot_d;
  logic               pulse_d, tick_d, ack_d, pend_d;
  logic [CNT_W-1:0]   lat_new, lat_new_d;
  logic [CNT_W-1:0]   lat_reconf, lat_reconf_d;
  logic               load;
  logic [CNT_W-1:0]   load_val;

  mt_gen #(.PRESC_W(PRESC_W)) u_mt_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .mtclk     (mtclk),
    .mt_sel    (mt_sel),
    .presc_div (presc_div),
    .mt_evt_c  (evt_c)
  );

  // Set FSM next state plus next counter/slot/pulse values; a load overrides the increment.
  always_comb begin
    state_d      = state;
    time_d       = time_cnt;
    slot_d       = slot_cnt;
    pulse_d      = evt_c;
    tick_d       = 1'b0;
    ack_d        = 1'b0;
    lat_new_d    = lat_new;
    lat_reconf_d = lat_reconf;
    load         = 1'b0;
    load_val     = new_time;

    case (state)
      ST_IDLE: begin
        if (set_req) begin
          if (!set_mode) begin
            load     = 1'b1;
            load_val = new_time;
          end else begin
            lat_new_d    = new_time;
            lat_reconf_d = reconf_time;
            state_d      = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (set_cancel) begin
          state_d = ST_IDLE;
        end else if (evt_c && (time_cnt == lat_reconf)) begin
          load     = 1'b1;
          load_val = lat_new;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      time_d = load_val;
      slot_d = '0;
      tick_d = (slot_len != '0);
      ack_d  = 1'b1;
    end else if (evt_c) begin
      time_d = time_cnt + CNT_W'(1);
      if (slot_len != '0) begin
        if (slot_cnt >= slot_len - SLOT_W'(1)) begin
          slot_d = '0;
          tick_d = 1'b1;
        end else begin
          slot_d = slot_cnt + SLOT_W'(1);
        end
      end
    end

    if (slot_len == '0) begin
      slot_d = '0;
    end

    pend_d = (state_d == ST_ARMED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      time_cnt    <= '0;
      slot_cnt    <= '0;
      mt_pulse    <= 1'b0;
      slot_tick   <= 1'b0;
      set_ack     <= 1'b0;
      set_pending <= 1'b0;
      lat_new     <= '0;
      lat_reconf  <= '0;
    end else begin
      state       <= state_d;
      time_cnt    <= time_d;
      slot_cnt    <= slot_d;
      mt_pulse    <= pulse_d;
      slot_tick   <= tick_d;
      set_ack     <= ack_d;
      set_pending <= pend_d;
      lat_new     <= lat_new_d;
      lat_reconf  <= lat_reconf_d;
    end
  end

endmodule
